// File: rtl/eprisc_pkg.sv
// Shared definitions for the epRISC interrupt controller: register word offsets,
// the VECTOR valid bit position and the default base address.
package eprisc_pkg;

    localparam logic [2:0]  INTC_PEND      = 3'd0;
    localparam logic [2:0]  INTC_ENABLE    = 3'd1;
    localparam logic [2:0]  INTC_VECTOR    = 3'd2;
    localparam logic [2:0]  INTC_NMISTAT   = 3'd3;
    localparam logic [2:0]  INTC_TRIGGER   = 3'd4;
    localparam logic [2:0]  INTC_SWSET     = 3'd5;

    localparam int          INTC_VEC_VALID = 31;
    localparam logic [31:0] INTC_BASE_ADDR = 32'hFFFF_FF00;

endpackage

// File: rtl/eprisc_sync.sv
// Two-flop synchroniser for asynchronous inputs, cleared by the synchronous reset.
module eprisc_sync #(
    parameter int pWidth = 1
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [pWidth-1:0] iAsync,
    output logic [pWidth-1:0] oSync
);

    logic [pWidth-1:0] r_stage1;
    logic [pWidth-1:0] r_stage2;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_stage1 <= '0;
            r_stage2 <= '0;
        end else begin
            r_stage1 <= iAsync;
            r_stage2 <= r_stage1;
        end
    end

    assign oSync = r_stage2;

endmodule

// File: rtl/eprisc_intctl.sv
// Memory-mapped interrupt controller for the epRISC system bus: latches, masks and
// prioritises external requests and drives the core's maskable and non-maskable inputs.
module eprisc_intctl
    import eprisc_pkg::*;
#(
    parameter int          pNumSrc   = 16,
    parameter logic [31:0] pBaseAddr = INTC_BASE_ADDR
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic [31:0]        iAddr,
    inout  wire  [31:0]        bData,
    input  logic               iWrite,
    input  logic [pNumSrc-1:0] iSrc,
    input  logic               iNmiSrc,
    output logic               oMaskInt,
    output logic               oNonMaskInt
);

    logic [pNumSrc-1:0] w_srcS2;
    logic [pNumSrc-1:0] r_srcS3;
    logic               w_nmiS2;
    logic               r_nmiS3;

    logic [pNumSrc-1:0] r_pend;
    logic [pNumSrc-1:0] r_enable;
    logic [pNumSrc-1:0] r_trigger;
    logic               r_nmiPend;

    logic               w_hit;
    logic [2:0]         w_offset;
    logic               w_wrStrobe;
    logic [pNumSrc-1:0] w_wrData;
    logic [pNumSrc-1:0] w_swSet;
    logic [pNumSrc-1:0] w_w1c;
    logic [pNumSrc-1:0] w_rise;
    logic [pNumSrc-1:0] w_edgeNext;
    logic [pNumSrc-1:0] w_levelNext;
    logic [pNumSrc-1:0] w_pendNext;
    logic [pNumSrc-1:0] w_active;
    logic               w_nmiNext;
    logic [31:0]        w_rdData;
    logic               w_unusedData;

    // Lowest index wins; returns 0 when nothing is set.
    function automatic logic [4:0] lowestSet(input logic [pNumSrc-1:0] vec);
        lowestSet = '0;
        for (int i = pNumSrc - 1; i >= 0; i--) begin
            if (vec[i]) lowestSet = 5'(i);
        end
    endfunction

    eprisc_sync #(.pWidth(pNumSrc)) u_srcSync (
        .iClk   (iClk),
        .iRst   (iRst),
        .iAsync (iSrc),
        .oSync  (w_srcS2)
    );

    eprisc_sync #(.pWidth(1)) u_nmiSync (
        .iClk   (iClk),
        .iRst   (iRst),
        .iAsync (iNmiSrc),
        .oSync  (w_nmiS2)
    );

    assign w_hit        = (iAddr[31:3] == pBaseAddr[31:3]);
    assign w_offset     = iAddr[2:0];
    assign w_wrStrobe   = w_hit && iWrite;
    assign w_wrData     = bData[pNumSrc-1:0];
    assign w_unusedData = ^bData[31:pNumSrc];

    assign w_swSet = (w_wrStrobe && (w_offset == INTC_SWSET)) ? w_wrData : '0;
    assign w_w1c   = (w_wrStrobe && (w_offset == INTC_PEND))  ? w_wrData : '0;
    assign w_rise  = w_srcS2 & ~r_srcS3;

    // Edge-mode bits are sticky with set beating clear; level-mode bits just follow the source.
    assign w_edgeNext  = (r_pend & ~w_w1c) | w_rise | w_swSet;
    assign w_levelNext = w_srcS2 | w_swSet;
    assign w_pendNext  = (r_trigger & w_edgeNext) | (~r_trigger & w_levelNext);

    assign w_nmiNext = (r_nmiPend & ~(w_wrStrobe && (w_offset == INTC_NMISTAT) && bData[0]))
                     | (w_nmiS2 & ~r_nmiS3);

    assign w_active = r_pend & r_enable;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_srcS3     <= '0;
            r_nmiS3     <= 1'b0;
            r_pend      <= '0;
            r_enable    <= '0;
            r_trigger   <= '1;
            r_nmiPend   <= 1'b0;
            oMaskInt    <= 1'b0;
            oNonMaskInt <= 1'b0;
        end else begin
            r_srcS3   <= w_srcS2;
            r_nmiS3   <= w_nmiS2;
            r_pend    <= w_pendNext;
            r_nmiPend <= w_nmiNext;
            if (w_wrStrobe && (w_offset == INTC_ENABLE))  r_enable  <= w_wrData;
            if (w_wrStrobe && (w_offset == INTC_TRIGGER)) r_trigger <= w_wrData;
            oMaskInt    <= |w_active;
            oNonMaskInt <= r_nmiPend;
        end
    end

    always_comb begin
        w_rdData = '0;
        case (w_offset)
            INTC_PEND:    w_rdData[pNumSrc-1:0] = r_pend;
            INTC_ENABLE:  w_rdData[pNumSrc-1:0] = r_enable;
            INTC_VECTOR: begin
                w_rdData[INTC_VEC_VALID] = |w_active;
                w_rdData[4:0]            = lowestSet(w_active);
            end
            INTC_NMISTAT: w_rdData[0]           = r_nmiPend;
            INTC_TRIGGER: w_rdData[pNumSrc-1:0] = r_trigger;
            default:      w_rdData              = '0;
        endcase
    end

    assign bData = (w_hit && !iWrite) ? w_rdData : 'z;

endmodule

// File: tb/tb_eprisc_intctl.sv
// Self-checking bench for eprisc_intctl: directed scenarios plus randomized bus and
// source activity compared against a cycle-level behavioural model of the register map.
module tb_eprisc_intctl;

    localparam int          NSRC = 16;
    localparam logic [31:0] BASE = 32'hFFFF_FF00;

    logic              iClk    = 1'b0;
    logic              iRst    = 1'b1;
    logic [31:0]       iAddr   = BASE;
    logic              iWrite  = 1'b0;
    logic [NSRC-1:0]   iSrc    = '0;
    logic              iNmiSrc = 1'b0;
    logic              oMaskInt;
    logic              oNonMaskInt;
    wire  [31:0]       bData;
    logic              wDrive  = 1'b0;
    logic [31:0]       wData   = '0;

    int checks = 0;
    int errors = 0;

    assign bData = wDrive ? wData : 'z;

    eprisc_intctl #(.pNumSrc(NSRC), .pBaseAddr(BASE)) dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iAddr       (iAddr),
        .bData       (bData),
        .iWrite      (iWrite),
        .iSrc        (iSrc),
        .iNmiSrc     (iNmiSrc),
        .oMaskInt    (oMaskInt),
        .oNonMaskInt (oNonMaskInt)
    );

    always #5 iClk = ~iClk;

    // Reference model: registers as the programmer sees them, plus the last three
    // per-edge samples of each source (the synchroniser delay seen from outside).
    logic [NSRC-1:0] mPend    = '0;
    logic [NSRC-1:0] mEnable  = '0;
    logic [NSRC-1:0] mTrigger = '1;
    logic            mNmi     = 1'b0;
    logic            mOutMask = 1'b0;
    logic            mOutNmi  = 1'b0;
    logic [NSRC-1:0] srcHist0 = '0, srcHist1 = '0, srcHist2 = '0;
    logic            nmiHist0 = 1'b0, nmiHist1 = 1'b0, nmiHist2 = 1'b0;

    function automatic logic modelWrHit(input logic [2:0] off);
        return iWrite && (iAddr[31:3] == BASE[31:3]) && (iAddr[2:0] == off);
    endfunction

    function automatic logic [NSRC-1:0] modelPend(input logic [NSRC-1:0] set,
                                                  input logic [NSRC-1:0] clr);
        logic [NSRC-1:0] nxt;
        for (int i = 0; i < NSRC; i++) begin
            if (mTrigger[i])
                nxt[i] = (mPend[i] && !clr[i]) || (srcHist1[i] && !srcHist2[i]) || set[i];
            else
                nxt[i] = srcHist1[i] || set[i];
        end
        return nxt;
    endfunction

    function automatic logic [31:0] modelRead(input logic [2:0] off);
        logic [31:0]     v   = '0;
        logic [NSRC-1:0] act = mPend & mEnable;
        case (off)
            3'd0: v[NSRC-1:0] = mPend;
            3'd1: v[NSRC-1:0] = mEnable;
            3'd2: for (int i = 0; i < NSRC; i++) if (act[i] && v == 32'd0) v = 32'h8000_0000 + 32'(i);
            3'd3: v[0] = mNmi;
            3'd4: v[NSRC-1:0] = mTrigger;
            default: v = '0;
        endcase
        return v;
    endfunction

    always @(posedge iClk) begin
        if (iRst) begin
            mPend <= '0; mEnable <= '0; mTrigger <= '1; mNmi <= 1'b0;
            mOutMask <= 1'b0; mOutNmi <= 1'b0;
            srcHist0 <= '0; srcHist1 <= '0; srcHist2 <= '0;
            nmiHist0 <= 1'b0; nmiHist1 <= 1'b0; nmiHist2 <= 1'b0;
        end else begin
            mOutMask <= |(mPend & mEnable);
            mOutNmi  <= mNmi;
            mPend    <= modelPend(modelWrHit(3'd5) ? wData[NSRC-1:0] : '0,
                                  modelWrHit(3'd0) ? wData[NSRC-1:0] : '0);
            mNmi     <= (mNmi && !(modelWrHit(3'd3) && wData[0])) || (nmiHist1 && !nmiHist2);
            if (modelWrHit(3'd1)) mEnable  <= wData[NSRC-1:0];
            if (modelWrHit(3'd4)) mTrigger <= wData[NSRC-1:0];
            srcHist0 <= iSrc;    srcHist1 <= srcHist0; srcHist2 <= srcHist1;
            nmiHist0 <= iNmiSrc; nmiHist1 <= nmiHist0; nmiHist2 <= nmiHist1;
        end
    end

    // Bus helpers: both start on a negedge; a write commits on the following posedge.
    task automatic busWrite(input logic [2:0] off, input logic [31:0] data);
        iAddr  = BASE | 32'(off);
        wData  = data;
        wDrive = 1'b1;
        iWrite = 1'b1;
        @(negedge iClk);
        iWrite = 1'b0;
        wDrive = 1'b0;
    endtask

    task automatic busRead(input logic [2:0] off, output logic [31:0] val);
        iAddr  = BASE | 32'(off);
        iWrite = 1'b0;
        #1;
        val = bData;
    endtask

    task automatic test_reset;
        logic [31:0] v, e;
        iRst = 1'b1;
        iSrc = 16'hFFFF;
        repeat (3) @(negedge iClk);
        for (int off = 0; off < 8; off++) begin
            if (off % 2 == 0) @(negedge iClk);
            busRead(3'(off), v);
            e = (off == 4) ? 32'h0000_FFFF : 32'h0;
            checks++; if (v !== e) begin errors++; $display("[TB] FAIL reset_reg%0d: got %h expected %h", off, v, e); end
        end
        checks++; if (oMaskInt !== 1'b0) begin errors++; $display("[TB] FAIL reset_maskint: got %b expected 0", oMaskInt); end
        checks++; if (oNonMaskInt !== 1'b0) begin errors++; $display("[TB] FAIL reset_nmi: got %b expected 0", oNonMaskInt); end
        iSrc = '0;
        repeat (3) @(negedge iClk);
        iRst = 1'b0;
        @(negedge iClk);
    endtask

    task automatic test_edge_basic;
        logic [31:0] v;
        busWrite(3'd1, 32'h0000_0010);
        iSrc[4] = 1'b1;
        @(negedge iClk);
        iSrc[4] = 1'b0;
        busRead(3'd0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL edge_pend_k: got %h expected %h", v, 32'h0); end
        @(negedge iClk);
        busRead(3'd0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL edge_pend_k1: got %h expected %h", v, 32'h0); end
        @(negedge iClk);
        busRead(3'd0, v);
        checks++; if (v !== 32'h10) begin errors++; $display("[TB] FAIL edge_pend_k2: got %h expected %h", v, 32'h10); end
        checks++; if (oMaskInt !== 1'b0) begin errors++; $display("[TB] FAIL edge_maskint_k2: got %b expected 0", oMaskInt); end
        @(negedge iClk);
        checks++; if (oMaskInt !== 1'b1) begin errors++; $display("[TB] FAIL edge_maskint_k3: got %b expected 1", oMaskInt); end
        busRead(3'd2, v);
        checks++; if (v !== 32'h8000_0004) begin errors++; $display("[TB] FAIL edge_vector: got %h expected %h", v, 32'h8000_0004); end
        busWrite(3'd0, 32'h0000_0010);
        checks++; if (oMaskInt !== 1'b1) begin errors++; $display("[TB] FAIL w1c_maskint_same: got %b expected 1", oMaskInt); end
        busRead(3'd0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL w1c_pend: got %h expected %h", v, 32'h0); end
        @(negedge iClk);
        checks++; if (oMaskInt !== 1'b0) begin errors++; $display("[TB] FAIL w1c_maskint_next: got %b expected 0", oMaskInt); end
    endtask

    task automatic test_priority;
        logic [31:0] v;
        busWrite(3'd1, 32'h0000_FFFF);
        iSrc = 16'h0208;
        @(negedge iClk);
        iSrc = '0;
        repeat (3) @(negedge iClk);
        busRead(3'd2, v);
        checks++; if (v !== 32'h8000_0003) begin errors++; $display("[TB] FAIL prio_vec_3: got %h expected %h", v, 32'h8000_0003); end
        checks++; if (oMaskInt !== 1'b1) begin errors++; $display("[TB] FAIL prio_maskint: got %b expected 1", oMaskInt); end
        busWrite(3'd0, 32'h0000_0008);
        busRead(3'd2, v);
        checks++; if (v !== 32'h8000_0009) begin errors++; $display("[TB] FAIL prio_vec_9: got %h expected %h", v, 32'h8000_0009); end
        busWrite(3'd0, 32'h0000_0200);
        busRead(3'd2, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL prio_vec_none: got %h expected %h", v, 32'h0); end
    endtask

    task automatic test_level;
        logic [31:0] v;
        busWrite(3'd4, 32'h0000_FFFB);
        iSrc[2] = 1'b1;
        repeat (4) @(negedge iClk);
        busRead(3'd0, v);
        checks++; if (v !== 32'h4) begin errors++; $display("[TB] FAIL level_pend_set: got %h expected %h", v, 32'h4); end
        busWrite(3'd0, 32'h0000_0004);
        busRead(3'd0, v);
        checks++; if (v !== 32'h4) begin errors++; $display("[TB] FAIL level_w1c_ignored: got %h expected %h", v, 32'h4); end
        iSrc[2] = 1'b0;
        @(negedge iClk);
        busRead(3'd0, v);
        checks++; if (v !== 32'h4) begin errors++; $display("[TB] FAIL level_drop_m: got %h expected %h", v, 32'h4); end
        @(negedge iClk);
        busRead(3'd0, v);
        checks++; if (v !== 32'h4) begin errors++; $display("[TB] FAIL level_drop_m1: got %h expected %h", v, 32'h4); end
        @(negedge iClk);
        busRead(3'd0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL level_drop_m2: got %h expected %h", v, 32'h0); end
        busWrite(3'd4, 32'hFFFF_FFFF);
        busRead(3'd4, v);
        checks++; if (v !== 32'h0000_FFFF) begin errors++; $display("[TB] FAIL width_trigger: got %h expected %h", v, 32'h0000_FFFF); end
        busWrite(3'd1, 32'hFFFF_0000);
        busRead(3'd1, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL width_enable: got %h expected %h", v, 32'h0); end
    endtask

    task automatic test_set_wins;
        logic [31:0] v;
        busWrite(3'd5, 32'h0000_0020);
        busRead(3'd0, v);
        checks++; if (v !== 32'h20) begin errors++; $display("[TB] FAIL swset_pend5: got %h expected %h", v, 32'h20); end
        busRead(3'd5, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL swset_reads0: got %h expected %h", v, 32'h0); end
        iSrc[5] = 1'b1;
        @(negedge iClk);
        @(negedge iClk);
        busWrite(3'd0, 32'h0000_0020);
        busRead(3'd0, v);
        checks++; if (v !== 32'h20) begin errors++; $display("[TB] FAIL setwins_pend5: got %h expected %h", v, 32'h20); end
        @(negedge iClk);
        busRead(3'd0, v);
        checks++; if (v !== 32'h20) begin errors++; $display("[TB] FAIL setwins_hold: got %h expected %h", v, 32'h20); end
        busWrite(3'd0, 32'h0000_0020);
        busRead(3'd0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL edge_w1c_clear: got %h expected %h", v, 32'h0); end
        iSrc[5] = 1'b0;
        repeat (3) @(negedge iClk);
        busWrite(3'd5, 32'h0000_0100);
        busRead(3'd0, v);
        checks++; if (v !== 32'h100) begin errors++; $display("[TB] FAIL swset_pend8: got %h expected %h", v, 32'h100); end
        busWrite(3'd0, 32'h0000_0100);
    endtask

    task automatic test_nmi_reset;
        logic [31:0] v;
        busWrite(3'd1, 32'h0);
        iNmiSrc = 1'b1;
        @(negedge iClk);
        iNmiSrc = 1'b0;
        @(negedge iClk);
        checks++; if (oNonMaskInt !== 1'b0) begin errors++; $display("[TB] FAIL nmi_out_k1: got %b expected 0", oNonMaskInt); end
        @(negedge iClk);
        busRead(3'd3, v);
        checks++; if (v !== 32'h1) begin errors++; $display("[TB] FAIL nmi_stat_k2: got %h expected %h", v, 32'h1); end
        checks++; if (oNonMaskInt !== 1'b0) begin errors++; $display("[TB] FAIL nmi_out_k2: got %b expected 0", oNonMaskInt); end
        @(negedge iClk);
        checks++; if (oNonMaskInt !== 1'b1) begin errors++; $display("[TB] FAIL nmi_out_k3: got %b expected 1", oNonMaskInt); end
        checks++; if (oMaskInt !== 1'b0) begin errors++; $display("[TB] FAIL nmi_maskint: got %b expected 0", oMaskInt); end
        busWrite(3'd3, 32'h1);
        busRead(3'd3, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL nmi_w1c_stat: got %h expected %h", v, 32'h0); end
        @(negedge iClk);
        checks++; if (oNonMaskInt !== 1'b0) begin errors++; $display("[TB] FAIL nmi_w1c_out: got %b expected 0", oNonMaskInt); end
        busWrite(3'd1, 32'h0000_00FF);
        busWrite(3'd5, 32'h0000_00F0);
        iNmiSrc = 1'b1;
        repeat (4) @(negedge iClk);
        iNmiSrc = 1'b0;
        checks++; if (oMaskInt !== 1'b1 || oNonMaskInt !== 1'b1) begin errors++; $display("[TB] FAIL prereset_outs: got %b%b expected 11", oMaskInt, oNonMaskInt); end
        iRst = 1'b1;
        @(negedge iClk);
        iRst = 1'b0;
        checks++; if (oMaskInt !== 1'b0 || oNonMaskInt !== 1'b0) begin errors++; $display("[TB] FAIL midreset_outs: got %b%b expected 00", oMaskInt, oNonMaskInt); end
        busRead(3'd0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL midreset_pend: got %h expected %h", v, 32'h0); end
        busRead(3'd1, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL midreset_enable: got %h expected %h", v, 32'h0); end
        @(negedge iClk);
        busRead(3'd3, v);
        checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL midreset_nmistat: got %h expected %h", v, 32'h0); end
        busRead(3'd4, v);
        checks++; if (v !== 32'h0000_FFFF) begin errors++; $display("[TB] FAIL midreset_trigger: got %h expected %h", v, 32'h0000_FFFF); end
    endtask

    task automatic test_random;
        logic [31:0] v, e;
        logic [2:0]  off;
        for (int n = 0; n < 800; n++) begin
            @(negedge iClk);
            iWrite = 1'b0;
            wDrive = 1'b0;
            iRst   = 1'b0;
            checks++; if (oMaskInt !== mOutMask) begin errors++; $display("[TB] FAIL rand_maskint@%0d: got %b expected %b", n, oMaskInt, mOutMask); end
            checks++; if (oNonMaskInt !== mOutNmi) begin errors++; $display("[TB] FAIL rand_nmi@%0d: got %b expected %b", n, oNonMaskInt, mOutNmi); end
            if ($urandom_range(0, 3) == 0) iSrc = iSrc ^ (NSRC'(1) << $urandom_range(0, NSRC - 1));
            if ($urandom_range(0, 9) == 0) iNmiSrc = !iNmiSrc;
            if ($urandom_range(0, 249) == 0) iRst = 1'b1;
            off = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) < 3) begin
                if ($urandom_range(0, 7) == 0)
                    iAddr = (BASE ^ (32'h8 << $urandom_range(0, 28))) | 32'(off);
                else
                    iAddr = BASE | 32'(off);
                wData  = $urandom;
                wDrive = 1'b1;
                iWrite = 1'b1;
            end else begin
                busRead(off, v);
                e = modelRead(off);
                checks++; if (v !== e) begin errors++; $display("[TB] FAIL rand_read%0d@%0d: got %h expected %h", off, n, v, e); end
            end
        end
        @(negedge iClk);
        iWrite = 1'b0;
        wDrive = 1'b0;
        iRst   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_edge_basic();
        test_priority();
        test_level();
        test_set_wins();
        test_nmi_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
